// File: rtl/fpu_norm_pipe_if.sv
// Handshake and data bundle for the post-add normaliser: an input beat channel
// and a result channel, each with valid/ready flow control.
interface fpu_norm_pipe_if #(
    parameter int SIG_W = 25,
    parameter int EXP_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] in_sig;
    logic [EXP_W-1:0] in_exp;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] out_sig;
    logic [EXP_W-1:0] out_exp;
    logic             out_sign;
    logic             out_zero;
    logic             out_uf;

    modport master (
        output in_valid, in_sig, in_exp, in_signed, out_ready,
        input  in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_uf
    );

    modport slave (
        input  in_valid, in_sig, in_exp, in_signed, out_ready,
        output in_ready, out_valid, out_sig, out_exp, out_sign, out_zero, out_uf
    );
endinterface

// File: rtl/fpu_norm_pipe.sv
// Two-stage post-add normaliser: S1 takes the magnitude and counts leading zeros,
// S2 shifts left and lowers the exponent, clamping at zero for denormal results.
module fpu_norm_pipe #(
    parameter int SIG_W = 25,
    parameter int EXP_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    fpu_norm_pipe_if.slave bus
);
    localparam int SH_W  = $clog2(SIG_W + 1);
    localparam int CMP_W = EXP_W + SH_W;
    localparam logic [SIG_W-1:0] SIG_ONE = {{(SIG_W-1){1'b0}}, 1'b1};

    // Leading-zero count; the highest set bit is the last one hit scanning upward.
    function automatic logic [SH_W-1:0] lzc_f(input logic [SIG_W-1:0] v);
        logic [SH_W-1:0] n;
        n = SH_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (v[i]) n = SH_W'(SIG_W - 1 - i);
            else      n = n;
        end
        return n;
    endfunction

    logic             s1_valid_r;
    logic [SIG_W-1:0] s1_mag_r;
    logic [EXP_W-1:0] s1_exp_r;
    logic             s1_sign_r;
    logic [SH_W-1:0]  s1_lzc_r;
    logic             s1_zero_r;

    logic             out_valid_r;
    logic [SIG_W-1:0] out_sig_r;
    logic [EXP_W-1:0] out_exp_r;
    logic             out_sign_r;
    logic             out_zero_r;
    logic             out_uf_r;

    logic             s2_free_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             neg_s;
    logic [SIG_W-1:0] mag_s;

    logic [CMP_W-1:0] lzc_w_s;
    logic [CMP_W-1:0] exp_w_s;
    logic [CMP_W-1:0] sh_s;
    logic             uf_raw_s;
    logic [SIG_W-1:0] n_sig_s;
    logic [EXP_W-1:0] n_exp_s;
    logic             n_uf_s;

    assign s2_free_s  = ~out_valid_r | bus.out_ready;
    assign in_ready_s = ~s1_valid_r | s2_free_s;
    assign accept_s   = bus.in_valid & in_ready_s;

    // Stage-1 magnitude: a negative two's-complement input is negated (max negative wraps to itself).
    always_comb begin
        neg_s = bus.in_signed & bus.in_sig[SIG_W-1];
        mag_s = bus.in_sig;
        if (neg_s) mag_s = ~bus.in_sig + SIG_ONE;
        else       mag_s = bus.in_sig;
    end

    // Stage-1 occupancy: refills whenever the stage can hand its beat on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             s1_valid_r <= 1'b0;
        else if (in_ready_s) s1_valid_r <= bus.in_valid;
    end

    // Stage-1 payload; only meaningful while s1_valid_r is set, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            s1_mag_r  <= mag_s;
            s1_exp_r  <= bus.in_exp;
            s1_sign_r <= neg_s;
            s1_lzc_r  <= lzc_f(mag_s);
            s1_zero_r <= (mag_s == '0);
        end
    end

    // Stage-2 shift amount is the leading-zero count limited by the exponent headroom.
    always_comb begin
        lzc_w_s  = CMP_W'(s1_lzc_r);
        exp_w_s  = CMP_W'(s1_exp_r);
        uf_raw_s = (lzc_w_s > exp_w_s);
        sh_s     = uf_raw_s ? exp_w_s : lzc_w_s;
        n_sig_s  = '0;
        n_exp_s  = '0;
        n_uf_s   = 1'b0;
        if (s1_zero_r) begin
            n_sig_s = '0;
            n_exp_s = '0;
            n_uf_s  = 1'b0;
        end else begin
            n_sig_s = s1_mag_r << sh_s;
            n_exp_s = s1_exp_r - sh_s[EXP_W-1:0];
            n_uf_s  = uf_raw_s;
        end
    end

    // Result registers hold steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sig_r   <= '0;
            out_exp_r   <= '0;
            out_sign_r  <= 1'b0;
            out_zero_r  <= 1'b0;
            out_uf_r    <= 1'b0;
        end else if (s2_free_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_sig_r  <= n_sig_s;
                out_exp_r  <= n_exp_s;
                out_sign_r <= s1_sign_r;
                out_zero_r <= s1_zero_r;
                out_uf_r   <= n_uf_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sig   = out_sig_r;
    assign bus.out_exp   = out_exp_r;
    assign bus.out_sign  = out_sign_r;
    assign bus.out_zero  = out_zero_r;
    assign bus.out_uf    = out_uf_r;
endmodule
